rr_arb_mux: RTL and testbench
=============================

RR_ARB_MUX -- requirements
Module: rr_arb_mux

Interface
REQ-001 SHALL have parameter WIDTH, default 32: bit width of each data channel.
REQ-002 SHALL have parameter N, default 4: number of input channels; legal range 2..16.
REQ-003 SHALL have parameter SELW, default 2: index width, equal to clog2(N) with a minimum of 1.
REQ-004 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port mode  input  1  0 = round-robin arbitration, 1 = fixed priority with lowest index winning.
REQ-007 SHALL have port in_valid  input  N  per-channel request.
REQ-008 SHALL have port in_data  input  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
REQ-009 SHALL have port in_ready  output  N  per-channel accept, one-hot or zero.
REQ-010 SHALL have port out_valid  output  1  output register holds valid data.
REQ-011 SHALL have port out_data  output  WIDTH  registered selected data.
REQ-012 SHALL have port out_sel  output  SELW  index of the channel that produced out_data.
REQ-013 SHALL have port out_ready  input  1  downstream accept.

Function
REQ-014 SHALL compute a combinational grant vector, one-hot or zero, from in_valid, mode and the priority pointer ptr.
REQ-015 In round-robin mode, SHALL search channels ptr, ptr+1, ..., ptr+N-1 (mod N) and grant the first one with in_valid set.
REQ-016 In fixed-priority mode, SHALL grant the lowest-index channel with in_valid set and ignore ptr.
REQ-017 SHALL define load = (~out_valid | out_ready) & (|in_valid).
REQ-018 SHALL drive in_ready[i] = grant[i] & (~out_valid | out_ready); in_ready SHALL be 0 for every channel that is not granted.
REQ-019 A channel transfer SHALL occur when in_valid[i] & in_ready[i] is true.
REQ-020 On a transfer from channel g, SHALL register at the next edge: out_data = channel g data, out_sel = g, out_valid = 1.
REQ-021 Latency SHALL be exactly 1 cycle from input transfer to out_valid.
REQ-022 Throughput SHALL be 1 item per cycle while out_ready is held at 1.
REQ-023 While out_valid=1 and out_ready=0, SHALL hold out_data and out_sel stable and take no input transfer.
REQ-024 When out_valid=1, out_ready=1 and no in_valid is set, SHALL clear out_valid at the next edge; out_data SHALL keep its last value.
REQ-025 When out_ready=1 and a transfer occurs in the same cycle, SHALL drain the old item and load the new one with no bubble.
REQ-026 ptr SHALL update to (g+1) mod N only on a transfer in round-robin mode, with wrap from N-1 to 0.
REQ-027 ptr SHALL hold when there is no transfer or when mode=1.
REQ-028 mode changes SHALL take effect on the grant in the same cycle; ptr SHALL be preserved across mode switches.
REQ-029 An upstream channel that deasserts in_valid before it is granted SHALL lose nothing; no grant SHALL be stored across cycles.
REQ-030 If N is not a power of two, ptr SHALL never hold a value of N or greater.

Reset
REQ-031 While reset=1, asynchronously: out_valid=0, out_data=0, out_sel=0, ptr=0.
REQ-032 While reset=1, in_ready SHALL be all zeros, regardless of in_valid.
REQ-033 Reset asserted mid-transfer SHALL discard the held item; the first post-reset round-robin grant SHALL go to channel 0 if channel 0 is requesting.

Verification
REQ-034 Round-robin fairness: N=4, mode=0, in_valid=4'b1111, out_ready=1, data channel i = 32'hA0+i -> out_sel sequence 0,1,2,3,0 and out_data A0,A1,A2,A3,A0 on consecutive cycles.
REQ-035 Fixed priority: mode=1, in_valid=4'b1010 held for 3 cycles -> out_sel=1 each cycle; in_ready=4'b0010; channel 3 is never granted.
REQ-036 Backpressure: load channel 2 with 32'hDEAD, then out_ready=0 for 5 cycles while in_valid=4'b1111 -> out_data=32'hDEAD, out_sel=2, in_ready=0 throughout; after out_ready=1, the next out_sel is 3.
REQ-037 Wrap and sparse requests: ptr=3, in_valid=4'b0101 -> grant channel 0, then channel 2; ptr ends at 3.
REQ-038 Async reset mid-stream: assert reset between clock edges while out_valid=1 -> out_valid=0 and in_ready=0 immediately; after release with in_valid=4'b1001 -> first out_sel=0.
REQ-039 Parameter sweep: N=3, WIDTH=8, all channels requesting -> out_sel sequence 0,1,2,0 and ptr never equals 3.

Source files
------------

// File: rtl/rr_arb_mux.sv
// rr_arb_mux: N-input arbiter feeding a single registered output slot.
// Selects one requesting channel per cycle (round-robin or fixed
// priority), forwards its data into a one-deep output register and
// handshakes upstream/downstream with valid/ready.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-high reset
//   mode       0 = round-robin, 1 = fixed priority (lowest index wins)
//   in_valid   per-channel request
//   in_data    packed channel data, channel i at [i*WIDTH +: WIDTH]
//   in_ready   per-channel accept (combinational, one-hot or zero)
//   out_valid  output register holds valid data
//   out_data   registered selected data
//   out_sel    index of the channel that produced out_data
//   out_ready  downstream accept
module rr_arb_mux #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned N     = 4,
  parameter int unsigned SELW  = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 mode,
  input  logic [N-1:0]         in_valid,
  input  logic [N*WIDTH-1:0]   in_data,
  output logic [N-1:0]         in_ready,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_sel,
  input  logic                 out_ready
);

  // One extra bit so ptr + k never overflows before the modulo fold.
  localparam int unsigned IW = SELW + 1;

  logic [SELW-1:0]  ptr;
  logic [SELW-1:0]  start;
  logic [IW-1:0]    idx;
  logic [SELW-1:0]  idx_s;
  logic             found;
  logic [N-1:0]     grant;
  logic [SELW-1:0]  gidx;
  logic [WIDTH-1:0] sel_data;
  logic [SELW-1:0]  next_ptr;
  logic             accept;
  logic             load;

  // Output slot can take a new item when empty or draining this cycle.
  assign accept = ~out_valid | out_ready;
  assign load   = accept & (|in_valid);

  // Grant search: walk channels from the start point, first requester wins.
  // Fixed-priority mode simply starts the walk at 0.
  always_comb begin
    grant = '0;
    gidx  = '0;
    found = 1'b0;
    idx   = '0;
    idx_s = '0;
    start = mode ? '0 : ptr;
    for (int k = 0; k < int'(N); k++) begin
      idx = IW'(start) + IW'(k);
      if (idx >= IW'(N)) begin
        idx = idx - IW'(N);
      end
      idx_s = SELW'(idx);
      if (!found && in_valid[idx_s]) begin
        found        = 1'b1;
        grant[idx_s] = 1'b1;
        gidx         = idx_s;
      end
    end
  end

  // Data mux driven by the one-hot grant.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (grant[i]) begin
        sel_data = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Pointer advances past the winner, wrapping explicitly so non-power-of-two
  // N never reaches an out-of-range value.
  assign next_ptr = (gidx == SELW'(N - 1)) ? '0 : gidx + SELW'(1);

  // Ready is forced low during reset so nothing is accepted while clearing.
  assign in_ready = reset ? '0 : (grant & {N{accept}});

  // Output register and round-robin pointer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      ptr       <= '0;
    end else begin
      if (load) begin
        out_valid <= 1'b1;
        out_data  <= sel_data;
        out_sel   <= gidx;
        if (!mode) begin
          ptr <= next_ptr;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rr_arb_mux.sv
module tb_rr_arb_mux;

  logic         clk;
  logic         reset;
  logic         mode;
  logic [3:0]   in_valid;
  logic [127:0] in_data;
  logic [3:0]   in_ready;
  logic         out_valid;
  logic [31:0]  out_data;
  logic [1:0]   out_sel;
  logic         out_ready;

  logic [2:0]   in_valid3;
  logic [23:0]  in_data3;
  logic [2:0]   in_ready3;
  logic         out_valid3;
  logic [7:0]   out_data3;
  logic [1:0]   out_sel3;

  int n_tests = 0;
  int n_fail  = 0;

  rr_arb_mux #(.WIDTH(32), .N(4), .SELW(2)) dut (
    .clk(clk), .reset(reset), .mode(mode),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_sel(out_sel),
    .out_ready(out_ready)
  );

  rr_arb_mux #(.WIDTH(8), .N(3), .SELW(2)) dut3 (
    .clk(clk), .reset(reset), .mode(1'b0),
    .in_valid(in_valid3), .in_data(in_data3), .in_ready(in_ready3),
    .out_valid(out_valid3), .out_data(out_data3), .out_sel(out_sel3),
    .out_ready(1'b1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arbitration: first requester found walking from the start point.
  function automatic int pick(input int n, input int p, input bit fixed, input logic [15:0] v);
    int s;
    int c;
    s = fixed ? 0 : p;
    for (int k = 0; k < n; k++) begin
      c = (s + k) % n;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  // Model state: one output slot plus priority pointer, per instance.
  bit          mv, mv3;
  logic [31:0] md;
  logic [7:0]  md3;
  int          ms, ms3, mp, mp3;

  always @(posedge clk or posedge reset) begin
    int g;
    if (reset) begin
      mv = 0; md = '0; ms = 0; mp = 0;
      mv3 = 0; md3 = '0; ms3 = 0; mp3 = 0;
    end else begin
      g = pick(4, mp, mode, 16'(in_valid));
      if ((!mv || out_ready) && g >= 0) begin
        mv = 1; md = in_data[g*32 +: 32]; ms = g;
        if (!mode) mp = (g + 1) % 4;
      end else if (out_ready) begin
        mv = 0;
      end
      g = pick(3, mp3, 1'b0, 16'(in_valid3));
      if (g >= 0) begin
        mv3 = 1; md3 = in_data3[g*8 +: 8]; ms3 = g;
        mp3 = (g + 1) % 3;
      end else begin
        mv3 = 0;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    int g;
    logic [3:0] er;
    logic [2:0] er3;
    g  = pick(4, mp, mode, 16'(in_valid));
    er = (!reset && g >= 0 && (!mv || out_ready)) ? 4'(1 << g) : 4'b0;
    chk("out_valid", 64'(out_valid), 64'(mv));
    chk("out_data",  64'(out_data),  64'(md));
    chk("out_sel",   64'(out_sel),   64'(ms));
    chk("in_ready",  64'(in_ready),  64'(er));
    g   = pick(3, mp3, 1'b0, 16'(in_valid3));
    er3 = (!reset && g >= 0) ? 3'(1 << g) : 3'b0;
    chk("n3_out_valid", 64'(out_valid3), 64'(mv3));
    chk("n3_out_data",  64'(out_data3),  64'(md3));
    chk("n3_out_sel",   64'(out_sel3),   64'(ms3));
    chk("n3_in_ready",  64'(in_ready3),  64'(er3));
    chk("n3_ptr_range", 64'(dut3.ptr < 2'd3), 64'd1);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp_sel[5];
    int exp_sel3[4];
    exp_sel  = '{0, 1, 2, 3, 0};
    exp_sel3 = '{0, 1, 2, 0};
    reset = 1'b1; mode = 1'b0; in_valid = '0; in_data = '0; out_ready = 1'b0;
    in_valid3 = 3'b111; in_data3 = 24'h12_34_56;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd0);
    repeat (2) cyc();
    reset = 1'b0;

    // Round-robin fairness, plus N=3 sweep on the second instance.
    for (int i = 0; i < 4; i++) in_data[i*32 +: 32] = 32'hA0 + 32'(i);
    in_valid = 4'b1111; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("rr_sel",  64'(out_sel),  64'(exp_sel[i]));
      chk("rr_data", 64'(out_data), 64'(32'hA0 + 32'(exp_sel[i])));
      if (i < 4) chk("n3_sel", 64'(out_sel3), 64'(exp_sel3[i]));
    end

    // Fixed priority: channel 1 always beats channel 3.
    mode = 1'b1; in_valid = 4'b1010;
    for (int i = 0; i < 3; i++) begin
      #1 chk("fp_ready", 64'(in_ready), 64'h2);
      cyc();
      chk("fp_sel", 64'(out_sel), 64'd1);
    end

    // Backpressure holds the DEAD item from channel 2.
    mode = 1'b0; in_valid = 4'b0100; in_data[64 +: 32] = 32'hDEAD;
    cyc();
    chk("bp_load_sel", 64'(out_sel), 64'd2);
    out_ready = 1'b0; in_valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      #1 chk("bp_ready", 64'(in_ready), 64'd0);
      cyc();
      chk("bp_data", 64'(out_data), 64'hDEAD);
      chk("bp_sel",  64'(out_sel),  64'd2);
    end
    out_ready = 1'b1;
    cyc();
    chk("bp_next_sel", 64'(out_sel), 64'd3);

    // Wrap with sparse requests from ptr=3.
    in_valid = 4'b0100;
    cyc();
    in_valid = 4'b0101;
    cyc();
    chk("wrap_sel0", 64'(out_sel), 64'd0);
    cyc();
    chk("wrap_sel2", 64'(out_sel), 64'd2);
    chk("wrap_ptr",  64'(dut.ptr), 64'd3);

    // Asynchronous reset between edges while holding valid data.
    in_valid = 4'b1111;
    cyc();
    chk("pre_rst_valid", 64'(out_valid), 64'd1);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("async_valid", 64'(out_valid), 64'd0);
    chk("async_ready", 64'(in_ready),  64'd0);
    in_valid = 4'b1001;
    cyc();
    reset = 1'b0;
    cyc();
    chk("post_rst_sel",   64'(out_sel),   64'd0);
    chk("post_rst_valid", 64'(out_valid), 64'd1);

    // Randomized traffic checked by the per-cycle compare process.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) mode = ~mode;
      in_valid  = 4'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      for (int c = 0; c < 4; c++) in_data[c*32 +: 32] = $urandom;
      in_valid3 = 3'($urandom);
      in_data3  = 24'($urandom);
      reset     = ($urandom_range(0, 299) == 0);
      cyc();
    end
    reset = 1'b0;
    cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
